// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 16-bit words from a loadable memory and issues each with a run pulse,
// waiting for done. Optional done watchdog is compiled in with `define SEQ_TIMEOUT_EN.
module instr_sequencer #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic          done,
    output logic [15:0]   instruction,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic [7:0]    issued_count
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_sequencer: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("instr_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   mem_word;
    logic          load_ok;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`endif

    // Writes are only accepted while no program is running; contents survive reset.
    assign load_ok  = load_en && (state == S_IDLE || state == S_HALT);
    assign mem_word = mem[pc];

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            instruction  <= '0;
            run          <= 1'b0;
            pc           <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            issued_count <= '0;
`ifdef SEQ_TIMEOUT_EN
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            run <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state        <= S_FETCH;
                        pc           <= '0;
                        issued_count <= '0;
                        busy         <= 1'b1;
                        halted       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        timeout_err  <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    instruction <= mem_word;
                    // A zero word ends the program without ever being issued.
                    if (mem_word == 16'h0000) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                        run   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (done) begin
                        issued_count <= issued_count + 8'd1;
                        if (pc == AW'(DEPTH - 1)) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_HALT;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a reference program walk predicts every issued {pc, instruction}
// pair; a monitor pops and compares on each run pulse. Timeout checks apply when SEQ_TIMEOUT_EN is defined.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = AW + 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic          done;
    logic [15:0]   instruction;
    logic          run;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic [7:0]    issued_count;
`ifdef SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .done         (done),
        .instruction  (instruction),
        .run          (run),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .issued_count (issued_count)
`ifdef SEQ_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    logic [15:0] mem_m [DEPTH];
    int          exp_pc;
    int          exp_cnt;
    bit          auto_done = 1'b0;
    int          done_delay = 3;
    logic        done_auto = 1'b0;
    logic        done_man  = 1'b0;
    logic        prev_run  = 1'b0;

    assign done = auto_done ? done_auto : done_man;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every run pulse must match the next predicted issue and last one cycle.
    always @(negedge clk) begin
        if (reset && run) begin
            check("run_width", {31'd0, prev_run}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run: pc=%0d instruction=0x%0h, no issue expected", pc, instruction);
            end else begin
                exp_e = exp_q.pop_front();
                check("issue_pc_instr", {12'd0, pc, instruction}, {12'd0, exp_e});
            end
        end
        prev_run <= run;
    end

    // Control-unit stand-in: answers each run with done after done_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && reset && run) begin
                repeat (done_delay) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        mem_m[a]  = d;
        tick(1);
        load_en   = 1'b0;
    endtask

    // Reference: issue words from address 0 until a zero word or the end of memory.
    task automatic model_start();
        exp_cnt = 0;
        exp_pc  = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_m[i] == 16'h0000) begin
                exp_pc = i;
                break;
            end
            exp_q.push_back({AW'(i), mem_m[i]});
            exp_cnt++;
        end
    endtask

    task automatic do_start();
        model_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("fetch_busy", {31'd0, busy}, 32'd1);
        check("fetch_run", {31'd0, run}, 32'd0);
        tick(1);
        check("issue_latency_run", {31'd0, run}, (exp_cnt > 0) ? 32'd1 : 32'd0);
        if (exp_cnt == 0) check("halt_word_halted", {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!run && n < budget);
        check("run_reached", {31'd0, run}, 32'd1);
    endtask

    task automatic finish_prog(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick(1);
            n++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_pc", {28'd0, pc}, 32'(exp_pc));
        check("halt_count", {24'd0, issued_count}, 32'(exp_cnt % 256));
        tick(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        int          len;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;

        // Reset values
        tick(2);
        check("rst_instruction", {16'd0, instruction}, 32'd0);
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_count", {24'd0, issued_count}, 32'd0);
        reset = 1'b1;
        tick(1);

        // Three-word program ending in HALT
        load_word(0, 16'h2408);
        load_word(1, 16'h4C10);
        load_word(2, 16'h0000);
        auto_done = 1'b1; done_delay = 3;
        do_start();
        finish_prog(100);
        check("prog3_count", {24'd0, issued_count}, 32'd2);
        check("prog3_pc", {28'd0, pc}, 32'd2);

        // End of memory: every word nonzero
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom_range(1, 16'hFFFF)));
        done_delay = $urandom_range(1, 4);
        do_start();
        finish_prog(400);
        check("eom_count", {24'd0, issued_count}, 32'd16);
        check("eom_pc", {28'd0, pc}, 32'd15);

        // Ignored start/load during WAIT and done during ISSUE
        for (int i = 0; i < 6; i++) load_word(i, 16'($urandom_range(1, 16'hFFFF)));
        load_word(6, 16'h0000);
        auto_done = 1'b0;
        do_start();
        done_man = 1'b1;
        tick(1);
        done_man  = 1'b0;
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd3;
        load_data = (mem_m[3] == 16'h5A5A) ? 16'hA5A5 : 16'h5A5A;
        tick(1);
        start = 1'b0; load_en = 1'b0;
        check("ign_pc", {28'd0, pc}, 32'd0);
        check("ign_busy", {31'd0, busy}, 32'd1);
        check("ign_run", {31'd0, run}, 32'd0);
        check("ign_count", {24'd0, issued_count}, 32'd0);
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
        auto_done = 1'b1; done_delay = 1;
        finish_prog(200);

        // Reset in the middle of WAIT
        for (int i = 0; i < 5; i++) load_word(i, 16'($urandom_range(1, 16'hFFFF)));
        load_word(5, 16'h0000);
        auto_done = 1'b0;
        do_start();
        tick(1);
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
        wait_run(10);
        tick(1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_q.delete();
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_pc", {28'd0, pc}, 32'd0);
        check("mrst_run", {31'd0, run}, 32'd0);
        check("mrst_count", {24'd0, issued_count}, 32'd0);
        check("mrst_instruction", {16'd0, instruction}, 32'd0);
        auto_done = 1'b1; done_delay = 2;
        do_start();
        finish_prog(200);

        // HALT word at address 0: nothing is issued
        load_word(0, 16'h0000);
        do_start();
        finish_prog(20);

        // Random programs; word 0 is written in the same cycle as start
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 1; i < DEPTH; i++) begin
                d = (i == len) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
                load_word(i, d);
            end
            d = 16'($urandom_range(1, 16'hFFFF));
            mem_m[0] = d;
            done_delay = $urandom_range(1, 5);
            model_start();
            load_en = 1'b1; load_addr = '0; load_data = d; start = 1'b1;
            tick(1);
            load_en = 1'b0; start = 1'b0;
            finish_prog(500);
        end

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: no done for 64 WAIT cycles
        load_word(0, 16'h1111);
        load_word(1, 16'h2222);
        load_word(2, 16'h0000);
        auto_done = 1'b0;
        do_start();
        tick(64);
        check("to_not_yet", {31'd0, halted}, 32'd0);
        tick(1);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_count", {24'd0, issued_count}, 32'd0);
        exp_q.delete();
        auto_done = 1'b1; done_delay = 1;
        do_start();
        check("to_cleared", {31'd0, timeout_err}, 32'd0);
        finish_prog(100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
